// File: rtl/mel_filterbank.sv
// mel_filterbank: streaming triangular mel filterbank over one power-spectrum frame; define MEL_FILTERBANK_SATURATE_EN to clamp outputs instead of wrapping
module mel_filterbank #(
  parameter int NUM_FILTERS        = 26,
  parameter int N_FFT              = 512,
  parameter int FREQ_LOWERBOUND_HZ = 20,
  parameter int FREQ_UPPERBOUND_HZ = 3000,
  parameter int SAMPLE_RATE_HZ     = 6000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] power_data_in,
  input  logic        power_valid_in,
  input  logic        power_last_in,
  output logic        power_ready_out,
  input  logic        filtered_ready_in,
  output logic        filtered_valid_out,
  output logic [31:0] filtered_data_out [NUM_FILTERS-1:0]
);
  localparam int RW = $clog2(NUM_FILTERS + 1);
  localparam int AW = $clog2(N_FFT);
  localparam int CW = $clog2(N_FFT + 1);
  localparam int EW = 1 + RW + 17;

  function automatic int bin_edge(input int i);
    real mlo, mhi, m, f;
    mlo = 2595.0 * $log10(1.0 + real'(FREQ_LOWERBOUND_HZ) / 700.0);
    mhi = 2595.0 * $log10(1.0 + real'(FREQ_UPPERBOUND_HZ) / 700.0);
    m = mlo + (mhi - mlo) * i / (NUM_FILTERS + 1);
    f = 700.0 * (10.0 ** (m / 2595.0) - 1.0);
    return $rtoi((N_FFT + 1) * f / SAMPLE_RATE_HZ);
  endfunction

  function automatic logic [N_FFT*EW-1:0] build_rom();
    logic [N_FFT*EW-1:0] t;
    int lo, hi;
    t = '0;
    for (int i = 0; i <= NUM_FILTERS; i++) begin
      lo = bin_edge(i);
      hi = bin_edge(i + 1);
      for (int k = lo; k < hi && k < N_FFT; k++)
        t[k*EW +: EW] = {1'b1, RW'(i), 17'(((k - lo) * 65536) / (hi - lo))};
    end
    return t;
  endfunction

  localparam logic [N_FFT*EW-1:0] ROM = build_rom();

  typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

  state_t        state, state_d;
  logic          live, accept, done;
  logic [CW-1:0] cnt;
  logic [EW-1:0] rom [N_FFT];
  logic [EW-1:0] ent;
  logic          s1_v;
  logic [RW-1:0] s1_r;
  logic [16:0]   s1_w;
  logic [31:0]   s1_p;
  logic [48:0]   p_hi, p_lo;

  assign accept             = power_valid_in && power_ready_out;
  assign power_ready_out    = live && state == ACCUM;
  assign filtered_valid_out = state == OUTPUT;
  assign done               = filtered_valid_out && filtered_ready_in;
  assign ent                = rom[cnt[AW-1:0]];
  assign p_hi               = {32'b0, s1_w} * {17'b0, s1_p};
  assign p_lo               = {32'b0, 17'h10000 - s1_w} * {17'b0, s1_p};

  // unpack the elaboration-time region/weight table into an addressable ROM
  always_comb
    for (int k = 0; k < N_FFT; k++) rom[k] = ROM[k*EW +: EW];

  // state register; live keeps ready low until the first clock after reset
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state <= ACCUM;
      live  <= 1'b0;
    end else begin
      state <= state_d;
      live  <= 1'b1;
    end

  // frame sequencing: accumulate, let the MAC pipeline drain, then hold the result
  always_comb begin
    state_d = state;
    case (state)
      ACCUM:   state_d = accept && power_last_in ? DRAIN : ACCUM;
      DRAIN:   state_d = OUTPUT;
      OUTPUT:  state_d = done ? ACCUM : OUTPUT;
      default: state_d = ACCUM;
    endcase
  end

  // bin counter and first pipeline stage: ROM lookup registered with the power
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      cnt  <= '0;
      s1_v <= 1'b0;
      s1_r <= '0;
      s1_w <= '0;
      s1_p <= '0;
    end else begin
      cnt  <= done ? '0 : accept && cnt < CW'(N_FFT) ? cnt + CW'(1) : cnt;
      s1_v <= accept && cnt < CW'(N_FFT) && ent[EW-1];
      s1_r <= ent[EW-2 -: RW];
      s1_w <= ent[16:0];
      s1_p <= power_data_in;
    end

  for (genvar j = 0; j < NUM_FILTERS; j++) begin : g_filt
    logic [55:0] acc;
    // second stage: rising edge from region j, falling edge from region j+1
    always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) acc <= '0;
      else if (done) acc <= '0;
      else if (s1_v) acc <= acc + (s1_r == RW'(j) ? {7'b0, p_hi} : 56'b0)
                                + (s1_r == RW'(j + 1) ? {7'b0, p_lo} : 56'b0);
`ifdef MEL_FILTERBANK_SATURATE_EN
    assign filtered_data_out[j] = !filtered_valid_out ? '0 : |acc[55:48] ? '1 : acc[47:16];
`else
    assign filtered_data_out[j] = filtered_valid_out ? acc[47:16] : '0;
`endif
  end
endmodule

// File: tb/tb_mel_filterbank.sv
// tb_mel_filterbank: randomized frames checked against a per-filter triangular reference model
module tb_mel_filterbank;
  localparam int NF = 26;
  localparam int NB = 512;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] power_data_in = '0;
  logic        power_valid_in = 1'b0;
  logic        power_last_in = 1'b0;
  logic        power_ready_out;
  logic        filtered_ready_in = 1'b0;
  logic        filtered_valid_out;
  logic [31:0] filtered_data_out [NF-1:0];

  int              vectors = 0;
  int              miscompares = 0;
  int              edge_b [NF+2];
  logic [31:0]     exp_out [NF];
  logic [31:0]     frame [$];
  longint unsigned out_sum;
  bit              all_nonzero;

  always #5 clk = ~clk;

  mel_filterbank dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .power_data_in(power_data_in),
    .power_valid_in(power_valid_in),
    .power_last_in(power_last_in),
    .power_ready_out(power_ready_out),
    .filtered_ready_in(filtered_ready_in),
    .filtered_valid_out(filtered_valid_out),
    .filtered_data_out(filtered_data_out)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int bin_edge(input int i);
    real mlo, mhi, m, f;
    mlo = 2595.0 * $log10(1.0 + 20 / 700.0);
    mhi = 2595.0 * $log10(1.0 + 3000 / 700.0);
    m = mlo + (mhi - mlo) * i / 27;
    f = 700.0 * (10.0 ** (m / 2595.0) - 1.0);
    return $rtoi(513 * f / 6000);
  endfunction

  task automatic model();
    for (int m = 0; m < NF; m++) begin
      longint unsigned a = 0, wt, s;
      int lo = edge_b[m], mid = edge_b[m+1], hi = edge_b[m+2];
      for (int k = 0; k < frame.size() && k < NB; k++) begin
        wt = 0;
        if (k >= lo && k < mid) wt = longint'((k - lo) * 65536 / (mid - lo));
        else if (k >= mid && k < hi) wt = 65536 - longint'((k - mid) * 65536 / (hi - mid));
        a += wt * frame[k];
      end
      s = (a & 64'h00FF_FFFF_FFFF_FFFF) >> 16;
`ifdef MEL_FILTERBANK_SATURATE_EN
      exp_out[m] = s > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : s[31:0];
`else
      exp_out[m] = s[31:0];
`endif
    end
  endtask

  task automatic check_outs(input string tag);
    for (int j = 0; j < NF; j++) check($sformatf("%s_out%0d", tag, j), filtered_data_out[j], exp_out[j]);
  endtask

  task automatic check_idle(input string tag);
    logic [31:0] orv = '0;
    for (int j = 0; j < NF; j++) orv |= filtered_data_out[j];
    check({tag, "_valid"}, filtered_valid_out, 0);
    check({tag, "_zero"}, orv, 0);
  endtask

  task automatic send_frame(input string tag, input int hold, input bit bubbles);
    model();
    foreach (frame[i]) begin
      if (bubbles) while ($urandom_range(0, 3) == 0) begin
        power_valid_in = 1'b0;
        @(posedge clk); #1;
      end
      power_valid_in = 1'b1;
      power_data_in  = frame[i];
      power_last_in  = i == frame.size() - 1;
      if (power_ready_out !== 1'b1) check({tag, "_ready_accum"}, power_ready_out, 1);
      @(posedge clk); #1;
    end
    power_valid_in = 1'b0;
    power_last_in  = 1'b0;
    check({tag, "_valid_t1"}, filtered_valid_out, 0);
    check({tag, "_ready_drain"}, power_ready_out, 0);
    @(posedge clk); #1;
    check({tag, "_valid_t2"}, filtered_valid_out, 1);
    for (int c = 0; c < hold; c++) begin
      check({tag, "_hold_valid"}, filtered_valid_out, 1);
      check({tag, "_hold_ready"}, power_ready_out, 0);
      check_outs({tag, "_hold"});
      @(posedge clk); #1;
    end
    filtered_ready_in = 1'b1;
    check_outs(tag);
    out_sum = 0;
    all_nonzero = 1'b1;
    for (int j = 0; j < NF; j++) begin
      out_sum += filtered_data_out[j];
      if (filtered_data_out[j] == 0) all_nonzero = 1'b0;
    end
    @(posedge clk); #1;
    filtered_ready_in = 1'b0;
    check_idle({tag, "_after"});
    check({tag, "_ready_next"}, power_ready_out, 1);
  endtask

  task automatic fill(input int n, input logic [31:0] v);
    frame.delete();
    for (int i = 0; i < n; i++) frame.push_back(v);
  endtask

  task automatic check_beef(input string tag);
    longint unsigned lo_b = 64'hBEEF * longint'(edge_b[NF] - edge_b[1]);
    longint unsigned hi_b = 64'hBEEF * longint'(edge_b[NF+1] - edge_b[0]);
    check({tag, "_nonzero"}, all_nonzero, 1);
    check({tag, "_sum_lo"}, out_sum * 1000 >= lo_b * 999, 1);
    check({tag, "_sum_hi"}, out_sum <= hi_b, 1);
  endtask

  initial begin
    for (int i = 0; i < NF + 2; i++) edge_b[i] = bin_edge(i);
    #2;
    check("rst_ready", power_ready_out, 0);
    check_idle("rst");
    #20 rst_in = 1'b1;
    #1 check("rel_ready_pre", power_ready_out, 0);
    @(posedge clk); #1;
    check("rel_ready", power_ready_out, 1);

    fill(NB, 32'h0);
    send_frame("zeros", 0, 0);

    fill(NB, 32'h0);
    frame[0] = 32'hFFFF_FFFF;
    for (int i = 257; i < NB; i++) frame[i] = 32'hFFFF_FFFF;
    send_frame("outside", 0, 0);

    fill(NB, 32'hBEEF);
    send_frame("beef", 0, 1);
    check_beef("beef");

    fill(NB, 32'hBEEF);
    send_frame("stall", 20, 0);
    frame.delete();
    for (int i = 0; i < NB; i++) frame.push_back($rtoi($sin(i / 5.0) ** 2 * 61453.0));
    send_frame("sin", 0, 1);

    for (int i = 0; i < 100; i++) begin
      power_valid_in = 1'b1;
      power_data_in  = 32'hBEEF;
      @(posedge clk); #1;
    end
    power_valid_in = 1'b0;
    rst_in = 1'b0;
    #2;
    check("midrst_ready", power_ready_out, 0);
    check_idle("midrst");
    #3 rst_in = 1'b1;
    #1 check("midrst_ready_pre", power_ready_out, 0);
    @(posedge clk); #1;
    check("midrst_ready_post", power_ready_out, 1);
    fill(NB, 32'hBEEF);
    send_frame("postrst", 0, 0);
    check_beef("postrst");

    fill(NB, 32'hFFFF_FFFF);
    send_frame("ones", 0, 0);

    fill(1, $urandom);
    send_frame("single", 1, 0);

    for (int f = 0; f < 6; f++) begin
      frame.delete();
      for (int i = $urandom_range(1, 600); i > 0; i--)
        frame.push_back($urandom_range(0, 1) ? $urandom : $urandom_range(0, 65535));
      send_frame($sformatf("rand%0d", f), $urandom_range(0, 5), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
